// File: rtl/lzx_dec_pkg.sv
// Shared definitions for the lzx scan decoder: mode encodings and the
// per-line active-low decode pattern.
package lzx_dec_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // One bit of the all-ones / one-hot-low pattern: line is low only when
   // enabled and addressed. Callers loop it over the 2**AW lines.
   function automatic logic line_n(input logic [31:0] addr,
                                   input logic [31:0] line,
                                   input logic        en);
      return !(en && (addr == line));
   endfunction

endpackage

// File: rtl/lzx_scan_decoder_onehot.sv
// Combinational AW-to-2**AW active-low line decoder with a single enable.
module lzx_onehot_dec
   import lzx_dec_pkg::*;
#(
   parameter int AW = 3
) (
   input  logic                 en,
   input  logic [AW-1:0]        a,
   output logic [(1<<AW)-1:0]   y_n
);

   always_comb begin
      y_n = '1;
      for (int i = 0; i < (1 << AW); i++) begin
         y_n[i] = line_n(32'(a), 32'(i), en);
      end
   end

endmodule

// File: rtl/lzx_scan_decoder.sv
// Registered 74HC138-style decoder with auto-scan. Define LZX_SCAN_BLANK_EN
// to insert one all-off blanking cycle on every scan advance.
module lzx_scan_decoder
   import lzx_dec_pkg::*;
#(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 e1_n,
   input  logic                 e2_n,
   input  logic                 e3,
   input  logic                 mode,
   input  logic [AW-1:0]        a,
   input  logic [DW-1:0]        dwell,
   input  logic [AW-1:0]        scan_last,
   output logic [(1<<AW)-1:0]   y_n,
   output logic [AW-1:0]        cur_addr,
   output logic                 frame_tick
);

   logic                 en;
   logic                 en_q;
   logic [AW-1:0]        scan_addr, scan_addr_nx;
   logic [DW-1:0]        dwell_cnt, dwell_cnt_nx, dwell_eff;
   logic                 advance, wrap;
   logic [AW-1:0]        dec_addr;
   logic                 dec_en;
   logic [(1<<AW)-1:0]   dec_y_n;

   assign en = !e1_n && !e2_n && e3;

   // en_q gates counting so the first enabled edge only loads the line.
   always_comb begin
      dwell_eff = dwell;
`ifdef LZX_SCAN_BLANK_EN
      if (dwell == '0) dwell_eff = DW'(1);
`endif
      advance      = en_q && (dwell_cnt == dwell_eff);
      wrap         = advance && (scan_addr >= scan_last);
      scan_addr_nx = scan_addr;
      dwell_cnt_nx = dwell_cnt;
      if (advance) begin
         dwell_cnt_nx = '0;
         scan_addr_nx = wrap ? '0 : scan_addr + 1'b1;
      end else if (en_q) begin
         dwell_cnt_nx = dwell_cnt + 1'b1;
      end
      dec_addr = (mode == MODE_SCAN) ? scan_addr_nx : a;
      dec_en   = 1'b1;
`ifdef LZX_SCAN_BLANK_EN
      if ((mode == MODE_SCAN) && advance) dec_en = 1'b0;
`endif
   end

   lzx_onehot_dec #(.AW(AW)) u_dec (
      .en  (dec_en),
      .a   (dec_addr),
      .y_n (dec_y_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         scan_addr  <= '0;
         dwell_cnt  <= '0;
         y_n        <= '1;
         cur_addr   <= '0;
         frame_tick <= 1'b0;
      end else begin
         en_q <= en;
         if (!en) begin
            y_n        <= '1;
            frame_tick <= 1'b0;
         end else begin
            y_n      <= dec_y_n;
            cur_addr <= dec_addr;
            if (mode == MODE_DIRECT) begin
               scan_addr  <= '0;
               dwell_cnt  <= '0;
               frame_tick <= 1'b0;
            end else begin
               scan_addr  <= scan_addr_nx;
               dwell_cnt  <= dwell_cnt_nx;
               frame_tick <= wrap;
            end
         end
      end
   end

endmodule

// File: tb/tb_lzx_scan_decoder.sv
// Self-checking bench for lzx_scan_decoder (AW=3, DW=8) with a behavioural
// line-visit model; honours LZX_SCAN_BLANK_EN when defined.
module tb_lzx_scan_decoder;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int W  = 12;

   logic          clk;
   logic          rst_n;
   logic          e1_n, e2_n, e3, mode;
   logic [AW-1:0] a, scan_last;
   logic [DW-1:0] dwell;
   logic [7:0]    y_n;
   logic [AW-1:0] cur_addr;
   logic          frame_tick;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] exp_q[$];

   lzx_scan_decoder #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .e1_n       (e1_n),
      .e2_n       (e2_n),
      .e3         (e3),
      .mode       (mode),
      .a          (a),
      .dwell      (dwell),
      .scan_last  (scan_last),
      .y_n        (y_n),
      .cur_addr   (cur_addr),
      .frame_tick (frame_tick)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: which line is lit and for how many cycles
   int         m_line, m_held;
   bit         m_was_on, m_ft;
   int         m_cur;
   logic [7:0] m_y;

   function automatic logic [7:0] lines_for(input int line);
      return 8'(255 - (1 << line));
   endfunction

   task automatic model_step();
      bit on;
      int limit;
      on = !e1_n && !e2_n && e3;
      if (!rst_n) begin
         m_line = 0; m_held = 0; m_was_on = 0; m_y = 8'hFF; m_cur = 0; m_ft = 0;
         return;
      end
      if (!on) begin
         m_y = 8'hFF;
         m_ft = 0;
      end else if (mode == 1'b0) begin
         m_line = 0; m_held = 0; m_ft = 0;
         m_cur = int'(a);
         m_y = lines_for(m_cur);
      end else begin
         limit = int'(dwell);
`ifdef LZX_SCAN_BLANK_EN
         if (limit == 0) limit = 1;
`endif
         if (m_was_on && m_held == limit) begin
            m_held = 0;
            m_ft = (m_line >= int'(scan_last));
            m_line = m_ft ? 0 : m_line + 1;
`ifdef LZX_SCAN_BLANK_EN
            m_y = 8'hFF;
`else
            m_y = lines_for(m_line);
`endif
         end else begin
            if (m_was_on) m_held = (m_held + 1) % 256;
            m_ft = 0;
            m_y = lines_for(m_line);
         end
         m_cur = m_line;
      end
      m_was_on = on;
   endtask

   // scoreboard: model expectation queued at the edge, compared just after
   always @(posedge clk) begin
      logic [W-1:0] e;
      model_step();
      exp_q.push_back({m_y, 3'(m_cur), m_ft});
      #1;
      e = exp_q.pop_front();
      check("model_y_n", int'(y_n), int'(e[11:4]));
      check("model_cur_addr", int'(cur_addr), int'(e[3:1]));
      check("model_frame_tick", int'(frame_tick), int'(e[0]));
      check("one_hot_low", int'($countones(~y_n) <= 1), 1);
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_en(input logic n1, input logic n2, input logic p3);
      e1_n = n1; e2_n = n2; e3 = p3;
   endtask

   task automatic expect_out(input string name, input logic [7:0] ey,
                             input int ec, input logic ef);
      check({name, "_y_n"}, int'(y_n), int'(ey));
      check({name, "_cur"}, int'(cur_addr), ec);
      check({name, "_ft"}, int'(frame_tick), int'(ef));
   endtask

   task automatic fresh_reset();
      rst_n = 1'b0;
      set_en(1'b1, 1'b1, 1'b0);
      step();
      rst_n = 1'b1;
   endtask

   logic [7:0] sweep_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] scan_exp [10] = '{8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFD,
                                 8'hFB, 8'hFB, 8'hFB, 8'hFE};
   logic [7:0] blank_exp [9] = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD,
                                 8'hFF, 8'hFE, 8'hFE};
   int         blank_cur [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
   logic [7:0] fast_exp [5]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFE};

   initial begin
      rst_n = 1'b0;
      set_en(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
      mode = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      dwell = 8'($urandom_range(0, 255));
      scan_last = 3'($urandom_range(0, 7));

      // reset held with random inputs, then released with enable off
      repeat (3) step();
      expect_out("reset", 8'hFF, 0, 1'b0);
      set_en(1'b1, 1'b0, 1'b1);
      mode = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();
      expect_out("post_reset", 8'hFF, 0, 1'b0);

      // enable truth table, a = 5
      a = 3'd5;
      set_en(1'b1, 1'b0, 1'b1); step(); check("en_e1", int'(y_n), 'hFF);
      set_en(1'b0, 1'b1, 1'b1); step(); check("en_e2", int'(y_n), 'hFF);
      set_en(1'b0, 1'b0, 1'b0); step(); check("en_e3", int'(y_n), 'hFF);
      set_en(1'b0, 1'b0, 1'b1); step(); expect_out("en_all", 8'hDF, 5, 1'b0);

      // direct sweep
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         step();
         expect_out("sweep", sweep_exp[i], i, 1'b0);
      end

      // scan dwell=2 scan_last=2, en rises just before e1
      set_en(1'b0, 1'b0, 1'b0);
      mode = 1'b1; dwell = 8'd2; scan_last = 3'd2;
      step();
      check("scan_idle_y_n", int'(y_n), 'hFF);
      set_en(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         expect_out("scan", scan_exp[i], (i < 3 || i == 9) ? 0 : (i < 6 ? 1 : 2), i == 9);
      end
      step(); expect_out("scan_e11", 8'hFE, 0, 1'b0);
      step(); expect_out("scan_e12", 8'hFE, 0, 1'b0);
      step(); expect_out("scan_e13", 8'hFD, 1, 1'b0);

      // freeze mid-line 1, then resume for 3 full cycles
      set_en(1'b0, 1'b0, 1'b0);
      step(); expect_out("freeze1", 8'hFF, 1, 1'b0);
      step(); expect_out("freeze2", 8'hFF, 1, 1'b0);
      set_en(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("resume", 8'hFD, 1, 1'b0);
      end
      step(); expect_out("resume_next", 8'hFB, 2, 1'b0);

      // reset asserted mid-scan clears outputs immediately
      rst_n = 1'b0;
      #1;
      expect_out("mid_reset", 8'hFF, 0, 1'b0);
      fresh_reset();

`ifdef LZX_SCAN_BLANK_EN
      mode = 1'b1; dwell = 8'd2; scan_last = 3'd1;
      set_en(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         step();
         expect_out("blank", blank_exp[i], blank_cur[i], i == 6);
      end
`else
      mode = 1'b1; dwell = 8'd0; scan_last = 3'd3;
      set_en(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         expect_out("dwell0", fast_exp[i], (i == 4) ? 0 : i, i == 4);
      end
`endif

      // scan_last lowered below the current line wraps at the next advance
      fresh_reset();
      mode = 1'b1; dwell = 8'd1; scan_last = 3'd7;
      set_en(1'b0, 1'b0, 1'b1);
      repeat (7) step();
      scan_last = 3'd1;
      repeat (2) step();

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         e1_n = ($urandom_range(0, 19) == 0);
         e2_n = ($urandom_range(0, 19) == 0);
         e3   = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) dwell = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) scan_last = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) fresh_reset();
         step();
      end

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lzx_scan_decoder.md
Name: lzx_scan_decoder

Overview:
- Parametrised, registered successor to the 3-to-8 line decoder with 74HC138-style enables (E1_n, E2_n, E3).
- Widens to AW address bits and 2**AW active-low lines.
- Adds an auto-scan mode: an internal dwell counter steps through lines 0..scan_last. Used to drive multiplexed LED matrices and 7-segment digit selects.
- Sits between the control logic and the board-level row/digit drivers.

Parameters:
AW, 3, address width; output width is 2**AW.
DW, 8, dwell counter width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
e1_n  input  1  enable, active low.
e2_n  input  1  enable, active low.
e3  input  1  enable, active high.
mode  input  1  0 = direct decode of a; 1 = auto-scan.
a  input  AW  direct-mode address.
dwell  input  DW  scan mode: each line is active for dwell+1 cycles.
scan_last  input  AW  scan mode: highest line index before wrap to 0.
y_n  output  2**AW  decoded lines, active low, registered.
cur_addr  output  AW  address currently decoded, registered.
frame_tick  output  1  one-cycle pulse when the scan wraps to 0.

Behaviour:
- One clock, clk. rst_n is asynchronous and active low.
- Reset values: y_n all ones, cur_addr 0, frame_tick 0. Internal scan_addr, dwell_cnt and en_q are all 0.
- en = !e1_n & !e2_n & e3. en_q is en registered.
- en low at an edge: y_n is set to all ones and frame_tick to 0. scan_addr, dwell_cnt and cur_addr hold.
- Direct mode (mode=0), en high: y_n <= ~(1 << a) and cur_addr <= a. Latency is 1 cycle.
- In direct mode, scan_addr and dwell_cnt are held at 0. Switching 0->1 therefore starts the scan at line 0 with a fresh count.
- Scan mode (mode=1), en high:
  - advance = en_q & (dwell_cnt == dwell).
  - When advance is true: dwell_cnt <= 0. scan_addr <= 0 if scan_addr >= scan_last, otherwise scan_addr+1. frame_tick <= 1 on the wrap, else 0.
  - Otherwise: dwell_cnt <= dwell_cnt + 1 when en_q is high, and holds when en_q is low.
  - This makes the first enabled edge load the line without counting, so every visit lasts dwell+1 cycles.
  - y_n and cur_addr are decoded from the next value of scan_addr, so they change on the same edge the address advances.
- dwell=0: the line changes every cycle.
- scan_last changed mid-scan to a value below scan_addr: the next advance wraps to 0 and pulses frame_tick.
- Mode 1->0: scan_addr and dwell_cnt clear on the next edge. Direct decode takes effect on that same edge.
- Dwell or scan_last change mid-line: takes effect from the next compare. No glitch on y_n.
- Reset asserted mid-scan: all state clears immediately.
- At most one bit of y_n is low at any time.

Optional Feature:
- Macro: LZX_SCAN_BLANK_EN. Affects scan mode only.
- Defined:
  - On every advance edge, y_n <= all ones (blanking cycle) while cur_addr already shows the new address.
  - The new line asserts on the following edge.
  - The per-line period stays dwell+1 cycles: 1 blank plus dwell active.
  - dwell=0 is treated as 1.
  - Purpose: anti-ghosting for LED matrices.
- Undefined: lines switch directly with no blank cycle.
- Direct mode is identical either way.

Decomposition:
- Package lzx_dec_pkg holds:
  - mode localparams MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - a function for the all-ones/one-hot-low pattern, parametrised by AW.
- One sub-module, lzx_onehot_dec: combinational AW-to-2**AW active-low decoder with a single enable input.
- All registers stay in lzx_scan_decoder.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> y_n=8'hFF, cur_addr=0, frame_tick=0. Release -> outputs unchanged until en is high.
- Enable truth: in mode 0 with a=3'b101, drive each of the three combinations e1_n=1, e2_n=1 and e3=0 (others enabling) -> y_n=8'hFF. All enabling -> y_n=8'hDF one cycle later.
- Direct sweep: mode 0, a=0..7 one per cycle -> y_n=FE,FD,FB,F7,EF,DF,BF,7F, each delayed 1 cycle.
- Scan: mode 1, dwell=2, scan_last=2, en rises before edge e1.
  - e1-e3: FE. e4-e6: FD. e7-e9: FB.
  - e10: FE with frame_tick=1 for exactly one cycle.
- Freeze and resume: drop en mid-line 1 after 1 visible cycle -> y_n=FF with cur_addr held. Re-enable -> line 1 shows 3 full cycles.
- Blank (LZX_SCAN_BLANK_EN): dwell=2, scan_last=1 -> e1-e3 FE, e4 FF with cur_addr=1, e5-e6 FD, e7 FF with frame_tick=1, e8-e9 FE.
